// File: rtl/uart_pkt_deframer.sv
// Packet deframer behind the UART byte receiver: finds SYNC | LEN | PAYLOAD | CHK packets and streams verified payloads.
// Optional inter-byte timeout is built only when UART_PKT_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module uart_pkt_deframer #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 100000,
  localparam int        LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_frame,
  input  logic             rx_done,
  input  logic             frame_error,
  output logic [7:0]       pkt_data,
  output logic             pkt_valid,
  input  logic             pkt_ready,
  output logic             pkt_last,
  output logic [LEN_W-1:0] pkt_len,
  output logic             err_chk,
  output logic             err_len,
  output logic             err_frame,
  output logic             err_ovr,
  output logic             err_tmo
);

  localparam logic [2:0] S_HUNT    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHK     = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;

  localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0] last_idx;
  logic [7:0]       chk_q, chk_d;
  logic [7:0]       data_q;
  logic             last_q;
  logic             err_chk_q, err_chk_d;
  logic             err_len_q, err_len_d;
  logic             err_frame_q, err_frame_d;
  logic             err_ovr_q, err_ovr_d;
  logic             buf_we;
  logic             timed;

  logic [7:0] pay_mem [MAX_LEN];

  assign last_idx = len_q - LEN_W'(1);
  assign timed    = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_tmo_q, err_tmo_d;
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    chk_d       = chk_q;
    err_chk_d   = 1'b0;
    err_len_d   = 1'b0;
    err_frame_d = 1'b0;
    err_ovr_d   = 1'b0;
    buf_we      = 1'b0;
    case (state_q)
      S_HUNT: begin
        if (rx_done && rx_frame == SYNC_BYTE) state_d = S_LEN;
      end
      S_LEN: begin
        if (rx_done) begin
          if (frame_error) begin
            err_frame_d = 1'b1;
            state_d     = S_HUNT;
          end else if (rx_frame == 8'd0 || rx_frame > MAX_LEN_B) begin
            err_len_d = 1'b1;
            state_d   = S_HUNT;
          end else begin
            len_d    = rx_frame[LEN_W-1:0];
            chk_d    = rx_frame;
            wr_ptr_d = '0;
            state_d  = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_done) begin
          if (frame_error) begin
            err_frame_d = 1'b1;
            state_d     = S_HUNT;
          end else begin
            buf_we   = 1'b1;
            chk_d    = chk_q ^ rx_frame;
            wr_ptr_d = wr_ptr_q + LEN_W'(1);
            if (wr_ptr_q == last_idx) state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (rx_done) begin
          if (frame_error) begin
            err_frame_d = 1'b1;
            state_d     = S_HUNT;
          end else if (rx_frame != chk_q) begin
            err_chk_d = 1'b1;
            state_d   = S_HUNT;
          end else begin
            rd_ptr_d = '0;
            state_d  = S_SEND;
          end
        end
      end
      S_SEND: begin
        // The payload buffer is busy being drained, so incoming bytes cannot be kept.
        if (rx_done) err_ovr_d = 1'b1;
        if (pkt_ready) begin
          if (last_q) state_d = S_HUNT;
          else        rd_ptr_d = rd_ptr_q + LEN_W'(1);
        end
      end
      default: state_d = S_HUNT;
    endcase
`ifdef UART_PKT_TIMEOUT_EN
    tmo_cnt_d = '0;
    err_tmo_d = 1'b0;
    if (timed && !rx_done) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        err_tmo_d = 1'b1;
        state_d   = S_HUNT;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (buf_we) pay_mem[wr_ptr_q[IDX_W-1:0]] <= rx_frame;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HUNT;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      chk_q       <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      err_chk_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_frame_q <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      chk_q       <= chk_d;
      // Prefetch the byte that will be presented next cycle so pkt_data is a plain register.
      data_q      <= (state_d == S_SEND) ? pay_mem[rd_ptr_d[IDX_W-1:0]] : 8'h00;
      last_q      <= (state_d == S_SEND) && (rd_ptr_d == last_idx);
      err_chk_q   <= err_chk_d;
      err_len_q   <= err_len_d;
      err_frame_q <= err_frame_d;
      err_ovr_q   <= err_ovr_d;
    end
  end

`ifdef UART_PKT_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_tmo_q <= err_tmo_d;
    end
  end
  assign err_tmo = err_tmo_q;
`else
  assign err_tmo = 1'b0;
`endif

  assign pkt_valid = (state_q == S_SEND);
  assign pkt_data  = data_q;
  assign pkt_last  = last_q;
  assign pkt_len   = len_q;
  assign err_chk   = err_chk_q;
  assign err_len   = err_len_q;
  assign err_frame = err_frame_q;
  assign err_ovr   = err_ovr_q;

endmodule

// File: tb/tb_uart_pkt_deframer.sv
// Self-checking bench for uart_pkt_deframer: fixed vectors plus randomized packet streams
// checked against a byte-stream parsing model; the timeout scenario follows UART_PKT_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_uart_pkt_deframer;

  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         MAX_LEN = 16;
  localparam int         TMO     = 50;
  localparam int         LEN_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rx_frame = 8'h00;
  logic             rx_done = 1'b0;
  logic             frame_error = 1'b0;
  logic             pkt_ready = 1'b0;
  logic [7:0]       pkt_data;
  logic             pkt_valid;
  logic             pkt_last;
  logic [LEN_W-1:0] pkt_len;
  logic             err_chk, err_len, err_frame, err_ovr, err_tmo;

  int total = 0;
  int bad   = 0;
  bit rdy_rand = 1'b0;

  logic [7:0] stim_b[$];
  bit         stim_fe[$];
  logic [7:0] exp_data[$];
  bit         exp_last[$];
  int         exp_len[$];
  int         e_chk, e_len, e_frm;
  logic [7:0] got_data[$];
  bit         got_last[$];
  int         c_chk, c_len, c_frm, c_ovr, c_tmo;

  bit               hold_prev = 1'b0;
  logic [7:0]       h_data;
  logic             h_last;
  logic [LEN_W-1:0] h_len;
  logic [7:0]       xd;
  bit               xl;
  int               xn;

  uart_pkt_deframer #(
    .SYNC_BYTE  (SYNC),
    .MAX_LEN    (MAX_LEN),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_frame   (rx_frame),
    .rx_done    (rx_done),
    .frame_error(frame_error),
    .pkt_data   (pkt_data),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_last   (pkt_last),
    .pkt_len    (pkt_len),
    .err_chk    (err_chk),
    .err_len    (err_len),
    .err_frame  (err_frame),
    .err_ovr    (err_ovr),
    .err_tmo    (err_tmo)
  );

  always #5 clk = ~clk;

  // Output monitor / scoreboard: sampled on the falling edge, between input updates.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        total++;
        if (pkt_valid !== 1'b1 || pkt_data !== h_data || pkt_last !== h_last || pkt_len !== h_len) begin
          bad++;
          $display("FAIL hold: valid=%b data=%h last=%b len=%0d, required valid=1 data=%h last=%b len=%0d",
                   pkt_valid, pkt_data, pkt_last, pkt_len, h_data, h_last, h_len);
        end
      end
      if (pkt_valid === 1'b1 && pkt_ready === 1'b1) begin
        got_data.push_back(pkt_data);
        got_last.push_back(pkt_last);
        total++;
        if (exp_data.size() == 0) begin
          bad++;
          $display("FAIL stream: unexpected byte %h last=%b, required no transfer", pkt_data, pkt_last);
        end else begin
          xd = exp_data.pop_front();
          xl = exp_last.pop_front();
          xn = exp_len.pop_front();
          if (pkt_data !== xd || pkt_last !== xl || int'(pkt_len) != xn) begin
            bad++;
            $display("FAIL stream: data=%h last=%b len=%0d, required data=%h last=%b len=%0d",
                     pkt_data, pkt_last, pkt_len, xd, xl, xn);
          end
        end
        $display("xfer data=%h last=%b len=%0d", pkt_data, pkt_last, pkt_len);
      end
      hold_prev = (pkt_valid === 1'b1) && (pkt_ready !== 1'b1);
      h_data = pkt_data;
      h_last = pkt_last;
      h_len  = pkt_len;
      if (err_chk   === 1'b1) c_chk++;
      if (err_len   === 1'b1) c_len++;
      if (err_frame === 1'b1) c_frm++;
      if (err_ovr   === 1'b1) c_ovr++;
      if (err_tmo   === 1'b1) c_tmo++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) pkt_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_b(input logic [7:0] b, input bit fe);
    stim_b.push_back(b);
    stim_fe.push_back(fe);
  endtask

  task automatic clear_all();
    stim_b.delete(); stim_fe.delete();
    exp_data.delete(); exp_last.delete(); exp_len.delete();
    got_data.delete(); got_last.delete();
    e_chk = 0; e_len = 0; e_frm = 0;
    c_chk = 0; c_len = 0; c_frm = 0; c_ovr = 0; c_tmo = 0;
  endtask

  // Reference: scan the byte list packet by packet, starting at a SYNC byte.
  task automatic model_run();
    int n, i, p, len;
    logic [7:0] sum;
    bit aborted;
    n = stim_b.size();
    i = 0;
    while (i < n) begin
      if (stim_b[i] != SYNC) i++;
      else if (i + 1 >= n) i = n;
      else if (stim_fe[i+1]) begin e_frm++; i += 2; end
      else begin
        len = int'(stim_b[i+1]);
        if (len == 0 || len > MAX_LEN) begin e_len++; i += 2; end
        else begin
          sum = stim_b[i+1];
          aborted = 1'b0;
          p = i + 2;
          while (!aborted && p < i + 2 + len) begin
            if (p >= n) begin aborted = 1'b1; i = n; end
            else if (stim_fe[p]) begin e_frm++; aborted = 1'b1; i = p + 1; end
            else begin sum ^= stim_b[p]; p++; end
          end
          if (!aborted) begin
            if (p >= n) i = n;
            else if (stim_fe[p]) begin e_frm++; i = p + 1; end
            else if (stim_b[p] != sum) begin e_chk++; i = p + 1; end
            else begin
              for (int k = 0; k < len; k++) begin
                exp_data.push_back(stim_b[i+2+k]);
                exp_last.push_back(k == len - 1);
                exp_len.push_back(len);
              end
              i = p + 1;
            end
          end
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fe, input int gap);
    int n = 0;
    while (pkt_valid === 1'b1 && n < 2000) begin tick(); n++; end
    rx_frame = b; frame_error = fe; rx_done = 1'b1;
    tick();
    rx_done = 1'b0; frame_error = 1'b0; rx_frame = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic drive_range(input int from, input int upto, input int gap_max);
    for (int i = from; i < upto; i++)
      send_byte(stim_b[i], stim_fe[i], $urandom_range(0, gap_max));
  endtask

  task automatic drain();
    int n = 0;
    while (pkt_valid === 1'b1 && n < 2000) begin tick(); n++; end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL drain: pkt_valid=%b after %0d cycles, required 0", pkt_valid, n);
    end
    repeat (3) tick();
  endtask

  task automatic load_vec(input int v);
    case (v)
      0: begin push_b(SYNC,0); push_b(8'h03,0); push_b(8'h11,0); push_b(8'h22,0); push_b(8'h33,0); push_b(8'h03,0); end
      1: begin push_b(SYNC,0); push_b(8'h03,0); push_b(8'h11,0); push_b(8'h22,0); push_b(8'h33,0); push_b(8'h04,0);
               push_b(SYNC,0); push_b(8'h03,0); push_b(8'h11,0); push_b(8'h22,0); push_b(8'h33,0); push_b(8'h03,0); end
      2: begin push_b(8'h00,0); push_b(8'hFF,1); push_b(8'h5A,0); push_b(SYNC,0); push_b(8'h00,0);
               push_b(SYNC,0); push_b(8'h11,0); end
      default: begin push_b(SYNC,0); push_b(8'h04,0); push_b(8'h10,0); push_b(8'h20,1);
               push_b(SYNC,0); push_b(8'h01,0); push_b(8'h7E,0); push_b(8'h7F,0); end
    endcase
  endtask

  task automatic gen_pkt(input int kind);
    int len, pos;
    logic [7:0] sum, b;
    len = $urandom_range(1, MAX_LEN);
    case (kind)
      0, 1: begin
        push_b(SYNC, 0); push_b(8'(len), 0);
        sum = 8'(len);
        for (int k = 0; k < len; k++) begin b = 8'($urandom); sum ^= b; push_b(b, 0); end
        if (kind == 1) sum ^= 8'($urandom_range(1, 255));
        push_b(sum, 0);
      end
      2: begin
        push_b(SYNC, 0);
        push_b(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)), 0);
      end
      3: begin
        pos = $urandom_range(0, len + 1);
        push_b(SYNC, 0); push_b(8'(len), pos == 0);
        for (int k = 1; k <= pos; k++) push_b(8'($urandom), k == pos);
      end
      default: begin
        for (int k = 0; k < $urandom_range(1, 3); k++) begin
          b = 8'($urandom);
          if (b == SYNC) b = 8'h5A;
          push_b(b, 1'($urandom_range(0, 1)));
        end
      end
    endcase
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    total++;
    if (pkt_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: pkt_valid=%b, required 0", pkt_valid);
    end
    total++;
    if ({pkt_data, pkt_last, pkt_len, err_chk, err_len, err_frame, err_ovr, err_tmo} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: data=%h last=%b len=%0d errs=%b%b%b%b%b, required all 0",
               pkt_data, pkt_last, pkt_len, err_chk, err_len, err_frame, err_ovr, err_tmo);
    end
    tick();
    rst_n = 1'b1;
    pkt_ready = 1'b1;
    tick();
  endtask

  task automatic test_spec_vectors();
    rdy_rand = 1'b0;
    pkt_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      clear_all();
      load_vec(v);
      model_run();
      drive_range(0, stim_b.size(), 1);
      drain();
      total++;
      if (exp_data.size() != 0 || c_chk != e_chk || c_len != e_len || c_frm != e_frm || c_ovr != 0 || c_tmo != 0) begin
        bad++;
        $display("FAIL vec%0d: left=%0d chk=%0d len=%0d frame=%0d ovr=%0d tmo=%0d, required left=0 chk=%0d len=%0d frame=%0d ovr=0 tmo=0",
                 v, exp_data.size(), c_chk, c_len, c_frm, c_ovr, c_tmo, e_chk, e_len, e_frm);
      end
      total++;
      if (v == 0 && (got_data.size() != 3 || got_data[2] !== 8'h33 || got_last[2] !== 1'b1 || got_last[1] !== 1'b0)) begin
        bad++;
        $display("FAIL vec0_tail: bytes=%0d last_byte=%h last=%b, required bytes=3 last_byte=33 last=1",
                 got_data.size(), got_data[got_data.size()-1], got_last[got_last.size()-1]);
      end
      $display("vec%0d: %0d bytes delivered, chk=%0d len=%0d frame=%0d", v, got_data.size(), c_chk, c_len, c_frm);
    end
  endtask

  task automatic test_random();
    rdy_rand = 1'b1;
    for (int it = 0; it < 40; it++) begin
      clear_all();
      for (int p = 0; p < $urandom_range(1, 4); p++) gen_pkt($urandom_range(0, 4));
      model_run();
      drive_range(0, stim_b.size(), 2);
      drain();
      total++;
      if (exp_data.size() != 0 || c_chk != e_chk || c_len != e_len || c_frm != e_frm || c_ovr != 0 || c_tmo != 0) begin
        bad++;
        $display("FAIL rand%0d: left=%0d chk=%0d len=%0d frame=%0d ovr=%0d tmo=%0d, required left=0 chk=%0d len=%0d frame=%0d ovr=0 tmo=0",
                 it, exp_data.size(), c_chk, c_len, c_frm, c_ovr, c_tmo, e_chk, e_len, e_frm);
      end
    end
    rdy_rand = 1'b0;
    pkt_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    rdy_rand = 1'b0;
    pkt_ready = 1'b1;
    clear_all();
    for (int p = 0; p < 3; p++) gen_pkt(0);
    model_run();
    drive_range(0, stim_b.size(), 0);
    drain();
    total++;
    if (exp_data.size() != 0 || got_data.size() == 0 || c_chk + c_len + c_frm + c_ovr + c_tmo != 0) begin
      bad++;
      $display("FAIL back_to_back: left=%0d got=%0d errs=%0d, required left=0 got>0 errs=0",
               exp_data.size(), got_data.size(), c_chk + c_len + c_frm + c_ovr + c_tmo);
    end
  endtask

  task automatic test_backpressure();
    rdy_rand = 1'b0;
    pkt_ready = 1'b0;
    clear_all();
    push_b(SYNC,0); push_b(8'h03,0); push_b(8'h01,0); push_b(8'h02,0); push_b(8'h03,0); push_b(8'h03,0);
    model_run();
    drive_range(0, stim_b.size(), 0);
    total++;
    if (pkt_valid !== 1'b1) begin
      bad++; $display("FAIL bp_valid: pkt_valid=%b after CHK byte, required 1", pkt_valid);
    end
    for (int c = 0; c < 6; c++) begin
      if (c == 1 || c == 3) begin
        rx_frame = (c == 1) ? SYNC : 8'h42;
        rx_done = 1'b1;
      end
      tick();
      rx_done = 1'b0;
    end
    pkt_ready = 1'b1;
    drain();
    total++;
    if (exp_data.size() != 0 || got_data.size() != 3 || c_ovr != 2 || c_chk + c_len + c_frm + c_tmo != 0) begin
      bad++;
      $display("FAIL backpressure: left=%0d got=%0d ovr=%0d other_errs=%0d, required left=0 got=3 ovr=2 other_errs=0",
               exp_data.size(), got_data.size(), c_ovr, c_chk + c_len + c_frm + c_tmo);
    end
  endtask

  task automatic test_timeout();
    rdy_rand = 1'b0;
    pkt_ready = 1'b1;
    clear_all();
    push_b(SYNC,0); push_b(8'h02,0); push_b(8'h55,0); push_b(8'h66,0); push_b(8'h31,0);
`ifdef UART_PKT_TIMEOUT_EN
    drive_range(0, 2, 0);
    repeat (TMO + 10) tick();
    drain();
    total++;
    if (c_tmo != 1 || got_data.size() != 0 || c_chk + c_len + c_frm + c_ovr != 0) begin
      bad++;
      $display("FAIL timeout: tmo=%0d got=%0d other_errs=%0d, required tmo=1 got=0 other_errs=0",
               c_tmo, got_data.size(), c_chk + c_len + c_frm + c_ovr);
    end
    clear_all();
    load_vec(3);
    model_run();
    drive_range(0, stim_b.size(), 0);
    drain();
    total++;
    if (exp_data.size() != 0 || got_data.size() != 1 || c_tmo != 0) begin
      bad++;
      $display("FAIL after_timeout: left=%0d got=%0d tmo=%0d, required left=0 got=1 tmo=0",
               exp_data.size(), got_data.size(), c_tmo);
    end
`else
    model_run();
    drive_range(0, 2, 0);
    repeat (TMO + 10) tick();
    drive_range(2, stim_b.size(), 0);
    drain();
    total++;
    if (exp_data.size() != 0 || got_data.size() != 2 || c_tmo != 0 || c_chk + c_len + c_frm + c_ovr != 0) begin
      bad++;
      $display("FAIL no_timeout: left=%0d got=%0d tmo=%0d other_errs=%0d, required left=0 got=2 tmo=0 other_errs=0",
               exp_data.size(), got_data.size(), c_tmo, c_chk + c_len + c_frm + c_ovr);
    end
`endif
  endtask

  task automatic test_reset_mid_send();
    rdy_rand = 1'b0;
    pkt_ready = 1'b0;
    clear_all();
    push_b(SYNC,0); push_b(8'h02,0); push_b(8'h01,0); push_b(8'h02,0); push_b(8'h01,0);
    drive_range(0, stim_b.size(), 0);
    total++;
    if (pkt_valid !== 1'b1) begin
      bad++; $display("FAIL rst_pre_valid: pkt_valid=%b, required 1", pkt_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (pkt_valid !== 1'b0) begin
      bad++; $display("FAIL rst_async: pkt_valid=%b during reset, required 0", pkt_valid);
    end
    @(negedge clk);
    total++;
    if ({pkt_valid, pkt_data, pkt_last, pkt_len} !== '0) begin
      bad++;
      $display("FAIL rst_outputs: valid=%b data=%h last=%b len=%0d, required all 0", pkt_valid, pkt_data, pkt_last, pkt_len);
    end
    tick();
    rst_n = 1'b1;
    pkt_ready = 1'b1;
    tick();
    clear_all();
    load_vec(0);
    model_run();
    drive_range(0, stim_b.size(), 0);
    drain();
    total++;
    if (exp_data.size() != 0 || got_data.size() != 3 || c_chk + c_len + c_frm + c_ovr + c_tmo != 0) begin
      bad++;
      $display("FAIL after_reset: left=%0d got=%0d errs=%0d, required left=0 got=3 errs=0",
               exp_data.size(), got_data.size(), c_chk + c_len + c_frm + c_ovr + c_tmo);
    end
  endtask

  initial begin
    clear_all();
    test_reset();
    test_spec_vectors();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
